xalu: RTL

XALU -- requirements
Module: xalu

---
 rtl/xalu_pkg.sv | 44 ++++
 rtl/xalu.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/xalu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op codes, latencies, FSM states.
// Optional build macro: XALU_MADD_EN enables the MADD/MADDU/MSUB accumulate ops.
package xalu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } xalu_state_e;

    // Accumulate codes only occupy the unit when the feature is built in.
    function automatic logic is_multi(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_multi = 1'b1;
`ifdef XALU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB:         is_multi = 1'b1;
`endif
            default:                            is_multi = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] op_latency(input logic [3:0] op);
        if (op == OP_DIV || op == OP_DIVU)
            op_latency = DIV_LAT;
        else
            op_latency = MUL_LAT;
    endfunction

endpackage

// File: rtl/xalu.sv
// HI/LO multiply-divide unit: result computed at accept, held in a pending register, committed after a fixed latency.
// Optional build macro: XALU_MADD_EN enables MADD/MADDU/MSUB (codes 9-11); otherwise they are NOPs.
module xalu
    import xalu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    xalu_state_e r_state;
    xalu_state_e w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_pend;

    logic        w_accept;
    logic        w_commit;
    logic        w_mthi;
    logic        w_mtlo;
    logic [63:0] w_pend;

    logic signed [63:0] w_a_s64;
    logic signed [63:0] w_b_s64;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [63:0] w_hilo;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_sdiv;
    logic [31:0] w_b_udiv;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign out  = (op == OP_MFHI) ? r_hi : r_lo;

    assign w_hilo   = {r_hi, r_lo};
    assign w_a_s64  = {{32{a[31]}}, a};
    assign w_b_s64  = {{32{b[31]}}, b};
    assign w_prod_s = w_a_s64 * w_b_s64;
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    assign w_a_mag  = a[31] ? (~a + 32'd1) : a;
    assign w_b_mag  = b[31] ? (~b + 32'd1) : b;
    assign w_b_sdiv = (b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_b_udiv = (b == 32'd0) ? 32'd1 : b;
    assign w_q_mag  = w_a_mag / w_b_sdiv;
    assign w_r_mag  = w_a_mag % w_b_sdiv;
    assign w_q_s    = (a[31] ^ b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r_s    = a[31] ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        w_pend = w_hilo;
        case (op)
            OP_MULT:  w_pend = w_prod_s;
            OP_MULTU: w_pend = w_prod_u;
            OP_DIV:   if (b != 32'd0) w_pend = {w_r_s, w_q_s};
            OP_DIVU:  if (b != 32'd0) w_pend = {a % w_b_udiv, a / w_b_udiv};
`ifdef XALU_MADD_EN
            OP_MADD:  w_pend = w_hilo + w_prod_s;
            OP_MADDU: w_pend = w_hilo + w_prod_u;
            OP_MSUB:  w_pend = w_hilo - w_prod_s;
`endif
            default:  w_pend = w_hilo;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (is_multi(op)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_mthi = (op == OP_MTHI);
                        w_mtlo = (op == OP_MTLO);
                    end
                end
            end
            ST_RUN: begin
                // Starts and flushes are ignored here; only the counter decides.
                if (r_cnt == 4'd1) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 4'd0;
            r_busy <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_pend <= 64'd0;
        end else begin
            if (w_accept) begin
                r_cnt  <= op_latency(op);
                r_busy <= 1'b1;
                r_pend <= w_pend;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_busy <= 1'b0;
                r_hi   <= r_pend[63:32];
                r_lo   <= r_pend[31:0];
            end
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
        end
    end

endmodule
